// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the uart command responder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RD       = 8'h52;
  localparam logic [7:0] CMD_WR       = 8'h57;
  localparam logic [7:0] RSP_OK       = 8'h4B;
  localparam logic [7:0] RSP_BAD      = 8'h3F;
  localparam logic [7:0] RSP_CSUM_ERR = 8'h45;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_CSUM,
    S_BUS_WR,
    S_BUS_RD,
    S_BUS_WAIT,
    S_SEND,
    S_SEND2
  } state_e;

  function automatic logic is_rx_state(state_e s);
    return (s == S_IDLE) || (s == S_GET_ADDR) || (s == S_GET_DATA) || (s == S_GET_CSUM);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: counts while enabled, flags expiry at TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES must be at least 2.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    cnt_d   = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses 'R'/'W' command packets from the uart rx FIFO, runs one register bus access,
// and pushes a response byte to the tx FIFO. Define UART_CMD_CSUM_EN for trailing XOR checksums.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int D_BITS         = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_empty,
  input  logic [D_BITS-1:0]    r_data,
  output logic                 rd_uart,
  input  logic                 tx_full,
  output logic [D_BITS-1:0]    w_data,
  output logic                 wr_uart,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [D_BITS-1:0]    bus_wdata,
  output logic                 bus_we,
  output logic                 bus_re,
  input  logic [D_BITS-1:0]    bus_rdata,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [D_BITS-1:0]      data_q, data_d;
  logic [D_BITS-1:0]      rsp_q, rsp_d;
  logic                   pop_q;
  logic                   pop, in_get, expired;
`ifdef UART_CMD_CSUM_EN
  logic [D_BITS-1:0]      csum_q, csum_d;
  logic                   two_q, two_d;
`endif

  // pop_q enforces the one-byte-per-two-cycles limit on rx pops
  always_comb begin
    in_get = is_rx_state(state_q) && (state_q != S_IDLE);
    pop    = is_rx_state(state_q) && !rx_empty && !pop_q && !reset;
  end

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (pop || !in_get),
    .enable (in_get),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    wr_uart = 1'b0;
`ifdef UART_CMD_CSUM_EN
    csum_d  = csum_q;
    two_d   = two_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef UART_CMD_CSUM_EN
        two_d = 1'b0;
`endif
        if (pop) begin
`ifdef UART_CMD_CSUM_EN
          csum_d = r_data;
`endif
          if (r_data == D_BITS'(CMD_RD)) begin
            op_wr_d = 1'b0;
            state_d = S_GET_ADDR;
          end else if (r_data == D_BITS'(CMD_WR)) begin
            op_wr_d = 1'b1;
            state_d = S_GET_ADDR;
          end else begin
            rsp_d   = D_BITS'(RSP_BAD);
            state_d = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (pop) begin
          addr_d = r_data[ADDR_BITS-1:0];
`ifdef UART_CMD_CSUM_EN
          csum_d  = csum_q ^ r_data;
          state_d = op_wr_q ? S_GET_DATA : S_GET_CSUM;
`else
          state_d = op_wr_q ? S_GET_DATA : S_BUS_RD;
`endif
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (pop) begin
          data_d = r_data;
`ifdef UART_CMD_CSUM_EN
          csum_d  = csum_q ^ r_data;
          state_d = S_GET_CSUM;
`else
          state_d = S_BUS_WR;
`endif
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_CMD_CSUM_EN
      S_GET_CSUM: begin
        if (pop) begin
          if (r_data == csum_q) begin
            state_d = op_wr_q ? S_BUS_WR : S_BUS_RD;
          end else begin
            rsp_d   = D_BITS'(RSP_CSUM_ERR);
            state_d = S_SEND;
          end
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_BUS_WR: begin
        rsp_d   = D_BITS'(RSP_OK);
        // Pass through BUS_WAIT so write and read responses land at the same latency
        state_d = S_BUS_WAIT;
      end
      S_BUS_RD: state_d = S_BUS_WAIT;
      S_BUS_WAIT: begin
        if (!op_wr_q) rsp_d = bus_rdata;
`ifdef UART_CMD_CSUM_EN
        two_d = !op_wr_q;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
`ifdef UART_CMD_CSUM_EN
          state_d = two_q ? S_SEND2 : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_CMD_CSUM_EN
      S_SEND2: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          two_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_uart   = pop;
    w_data    = rsp_q;
    bus_addr  = addr_q;
    bus_wdata = data_q;
    bus_we    = (state_q == S_BUS_WR);
    bus_re    = (state_q == S_BUS_RD);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      pop_q   <= 1'b0;
`ifdef UART_CMD_CSUM_EN
      csum_q  <= '0;
      two_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      pop_q   <= pop;
`ifdef UART_CMD_CSUM_EN
      csum_q  <= csum_d;
      two_q   <= two_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scenario bench for uart_cmd_responder: rx FIFO, tx FIFO and register bus modelled here,
// expected responses queued at stimulus time and checked as the DUT pushes them.
module tb_uart_cmd_responder;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset, rx_empty, tx_full;
  logic       rd_uart, wr_uart, bus_we, bus_re, busy;
  logic [7:0] r_data, w_data, bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .D_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_got[$];
  int         tx_cyc[$];
  logic [7:0] mem[256];
  logic [7:0] we_addr, we_data;
  logic       prev_rd;
  int cyc, we_cnt, re_cnt, rd_cnt, rd_consec, last_pop_cyc;
  int nvec, nmis;

  // One clock: sample DUT at negedge, then update FIFO/bus models just after the edge
  task automatic tick();
    logic       pop_now, re_now;
    logic [7:0] re_a;
    @(negedge clk);
    pop_now = rd_uart;
    if (rd_uart) begin
      rd_cnt++;
      last_pop_cyc = cyc;
      if (prev_rd) rd_consec++;
    end
    prev_rd = rd_uart;
    if (wr_uart) begin
      tx_got.push_back(w_data);
      tx_cyc.push_back(cyc);
    end
    if (bus_we) begin
      we_cnt++;
      we_addr = bus_addr;
      we_data = bus_wdata;
      mem[bus_addr] = bus_wdata;
    end
    re_now = bus_re;
    re_a   = bus_addr;
    if (bus_re) re_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && rxq.size() > 0) void'(rxq.pop_front());
    bus_rdata = re_now ? mem[re_a] : 8'hEE;
    rx_empty  = (rxq.size() == 0);
    r_data    = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic put(input logic [7:0] b);
    rxq.push_back(b);
    rx_empty = 1'b0;
    r_data   = rxq[0];
  endtask

  task automatic send_wr(input logic [7:0] a, input logic [7:0] d);
    put(8'h57); put(a); put(d);
`ifdef UART_CMD_CSUM_EN
    put(8'h57 ^ a ^ d);
`endif
    exp_q.push_back(8'h4B);
  endtask

  task automatic send_rd(input logic [7:0] a, input logic [7:0] v);
    put(8'h52); put(a);
`ifdef UART_CMD_CSUM_EN
    put(8'h52 ^ a);
    exp_q.push_back(v);
`endif
    exp_q.push_back(v);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int k = 0;
    while (tx_got.size() < n && k < 400) begin
      tick();
      k++;
    end
    ok = (tx_got.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    int r0;
    reset = 1'b1;
    tick(); tick();
    put(8'h41);
    r0 = rd_cnt;
    tick();
    nvec++;
    if ({rd_uart, wr_uart, bus_we, bus_re, busy, w_data, bus_addr, bus_wdata} !== 29'd0) begin
      nmis++;
      $display("FAIL reset_outputs: got %h want 0",
               {rd_uart, wr_uart, bus_we, bus_re, busy, w_data, bus_addr, bus_wdata});
    end
    nvec++;
    if (rd_cnt - r0 !== 0) begin nmis++; $display("FAIL reset_no_pop: got %0d pops want 0", rd_cnt - r0); end
    reset = 1'b0;
    exp_q.push_back(8'h3F);
    wait_tx(1, ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL reset_first_resp: got timeout want response"); end
    else begin
      nvec++;
      if (tx_cyc[0] - last_pop_cyc !== 1) begin
        nmis++; $display("FAIL bad_op_latency: got %0d want 1", tx_cyc[0] - last_pop_cyc);
      end
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL reset_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL reset_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_write();
    bit ok;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_wr(8'h10, 8'hA5);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL write_resp_wait: got timeout want response"); end
    else begin
      nvec++;
      if (tx_cyc[0] - last_pop_cyc !== 3) begin
        nmis++; $display("FAIL write_latency: got %0d want 3", tx_cyc[0] - last_pop_cyc);
      end
    end
    nvec++;
    if (we_cnt - we0 !== 1 || re_cnt - re0 !== 0) begin
      nmis++; $display("FAIL write_strobes: got we=%0d re=%0d want we=1 re=0", we_cnt - we0, re_cnt - re0);
    end
    nvec++;
    if ({we_addr, we_data} !== 16'h10A5) begin
      nmis++; $display("FAIL write_bus: got %h want 10a5", {we_addr, we_data});
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL write_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL write_resp: got %02h want %02h", g, e); end
      end
    end
    tick();
    nvec++;
    if (busy !== 1'b0) begin nmis++; $display("FAIL write_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_read();
    bit ok;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_rd(8'h10, 8'hA5);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL read_resp_wait: got timeout want response"); end
    else begin
      nvec++;
      if (tx_cyc[0] - last_pop_cyc !== 3) begin
        nmis++; $display("FAIL read_latency: got %0d want 3", tx_cyc[0] - last_pop_cyc);
      end
    end
    nvec++;
    if (we_cnt - we0 !== 0 || re_cnt - re0 !== 1) begin
      nmis++; $display("FAIL read_strobes: got we=%0d re=%0d want we=0 re=1", we_cnt - we0, re_cnt - re0);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL read_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL read_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_unknown();
    bit ok;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    put(8'h41);
    exp_q.push_back(8'h3F);
    wait_tx(1, ok);
    tick(); tick();
    nvec++;
    if (we_cnt - we0 !== 0 || re_cnt - re0 !== 0 || busy !== 1'b0) begin
      nmis++; $display("FAIL unknown_nobus: got we=%0d re=%0d busy=%b want 0 0 0", we_cnt - we0, re_cnt - re0, busy);
    end
    send_rd(8'h20, 8'h7A);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL unknown_wait: got timeout want responses"); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL unknown_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL unknown_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int we0, r0, k;
    we0 = we_cnt; r0 = rd_cnt; k = 0;
    put(8'h57); put(8'h20);
    while (rd_cnt - r0 < 2 && k < 50) begin tick(); k++; end
    repeat (T - 1) tick();
    nvec++;
    if (busy !== 1'b1) begin nmis++; $display("FAIL timeout_early: got busy=%b want 1", busy); end
    tick();
    nvec++;
    if (busy !== 1'b0) begin nmis++; $display("FAIL timeout_expire: got busy=%b want 0", busy); end
    repeat (5) tick();
    nvec++;
    if (we_cnt - we0 !== 0 || tx_got.size() !== 0) begin
      nmis++; $display("FAIL timeout_silent: got we=%0d tx=%0d want 0 0", we_cnt - we0, tx_got.size());
    end
    send_rd(8'h20, 8'h7A);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL timeout_next_wait: got timeout want response"); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL timeout_next_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL timeout_next_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_timeout_edge();
    bit ok;
    int r0, k;
    r0 = rd_cnt; k = 0;
    put(8'h57);
    while (rd_cnt - r0 < 1 && k < 50) begin tick(); k++; end
    repeat (T - 1) tick();
    nvec++;
    if (busy !== 1'b1) begin nmis++; $display("FAIL edge_busy: got busy=%b want 1", busy); end
    put(8'h30); put(8'h66);
`ifdef UART_CMD_CSUM_EN
    put(8'h57 ^ 8'h30 ^ 8'h66);
`endif
    exp_q.push_back(8'h4B);
    wait_tx(1, ok);
    nvec++;
    if ({we_addr, we_data} !== 16'h3066) begin
      nmis++; $display("FAIL edge_bus: got %h want 3066", {we_addr, we_data});
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL edge_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL edge_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    int rd0, rel;
    logic [7:0] w0;
    tx_full = 1'b1;
    send_rd(8'h10, 8'hA5);
    put(8'h41);
    exp_q.push_back(8'h3F);
    repeat (10) tick();
    w0 = w_data;
    nvec++;
    if (w0 !== 8'hA5) begin nmis++; $display("FAIL bp_hold_data: got %02h want a5", w0); end
    rd0 = rd_cnt; stable = 1'b1;
    repeat (100) begin
      tick();
      if (w_data !== w0) stable = 1'b0;
    end
    nvec++;
    if (tx_got.size() !== 0 || rd_cnt - rd0 !== 0 || !stable || busy !== 1'b1) begin
      nmis++; $display("FAIL bp_stall: got tx=%0d pops=%0d stable=%b busy=%b want 0 0 1 1",
                       tx_got.size(), rd_cnt - rd0, stable, busy);
    end
    rel = cyc;
    tx_full = 1'b0;
    tick();
    nvec++;
    if (tx_got.size() < 1) begin nmis++; $display("FAIL bp_release: got no push want push"); end
    else if (tx_cyc[0] !== rel) begin
      nmis++; $display("FAIL bp_release: got cycle %0d want %0d", tx_cyc[0], rel);
    end
    wait_tx(exp_q.size(), ok);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL bp_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL bp_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_wr(8'h40, 8'h11);
    send_rd(8'h40, 8'h11);
    put(8'h00); exp_q.push_back(8'h3F);
    send_wr(8'h41, 8'h22);
    send_rd(8'h41, 8'h22);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (!ok) begin nmis++; $display("FAIL b2b_wait: got timeout want responses"); end
    nvec++;
    if (we_cnt - we0 !== 2 || re_cnt - re0 !== 2) begin
      nmis++; $display("FAIL b2b_strobes: got we=%0d re=%0d want 2 2", we_cnt - we0, re_cnt - re0);
    end
    nvec++;
    if (rd_consec !== 0) begin nmis++; $display("FAIL rd_spacing: got %0d back-to-back pops want 0", rd_consec); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL b2b_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL b2b_resp: got %02h want %02h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int we0, r0, k;
    we0 = we_cnt; r0 = rd_cnt; k = 0;
    put(8'h57); put(8'h50); put(8'h77);
`ifdef UART_CMD_CSUM_EN
    put(8'h57 ^ 8'h50 ^ 8'h77);
`endif
    while (rd_cnt - r0 < 2 && k < 50) begin tick(); k++; end
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rxq.delete();
    rx_empty = 1'b1;
    r_data   = 8'h00;
    repeat (5) tick();
    nvec++;
    if (we_cnt - we0 !== 0 || tx_got.size() !== 0 || busy !== 1'b0) begin
      nmis++; $display("FAIL reset_mid: got we=%0d tx=%0d busy=%b want 0 0 0", we_cnt - we0, tx_got.size(), busy);
    end
    nvec++;
    if ({bus_addr, bus_wdata, w_data} !== 24'h0) begin
      nmis++; $display("FAIL reset_mid_outs: got %h want 0", {bus_addr, bus_wdata, w_data});
    end
  endtask

`ifdef UART_CMD_CSUM_EN
  task automatic test_csum();
    bit ok;
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    put(8'h57); put(8'h01); put(8'h02); put(8'h54);
    exp_q.push_back(8'h4B);
    put(8'h57); put(8'h01); put(8'h02); put(8'h00);
    exp_q.push_back(8'h45);
    put(8'h52); put(8'h01); put(8'h00);
    exp_q.push_back(8'h45);
    wait_tx(exp_q.size(), ok);
    nvec++;
    if (we_cnt - we0 !== 1 || re_cnt - re0 !== 0 || {we_addr, we_data} !== 16'h0102) begin
      nmis++; $display("FAIL csum_bus: got we=%0d re=%0d last=%h want 1 0 0102",
                       we_cnt - we0, re_cnt - re0, {we_addr, we_data});
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      nvec++;
      if (tx_got.size() == 0) begin nmis++; $display("FAIL csum_resp: got none want %02h", e); end
      else begin
        g = tx_got.pop_front(); void'(tx_cyc.pop_front());
        if (g !== e) begin nmis++; $display("FAIL csum_resp: got %02h want %02h", g, e); end
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0; bus_rdata = 8'hEE;
    prev_rd = 1'b0; we_addr = 8'h00; we_data = 8'h00;
    cyc = 0; we_cnt = 0; re_cnt = 0; rd_cnt = 0; rd_consec = 0; last_pop_cyc = 0;
    nvec = 0; nmis = 0;
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_timeout_edge();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_CMD_CSUM_EN
    test_csum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
